// File: rtl/seg7_dual_scan_if.sv
// Load/display bundle for the two-digit seven-segment scanner.
// The master side loads a value; the slave side reports status and drives the display.
interface seg7_dual_scan_if;
    logic [6:0] value;
    logic       load;
    logic       busy;
    logic       err;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output value,
        output load,
        input  busy,
        input  err,
        input  seg,
        input  an
    );

    modport slave (
        input  value,
        input  load,
        output busy,
        output err,
        output seg,
        output an
    );
endinterface

// File: rtl/seg7_dual_scan.sv
// Binary-to-BCD converter (serial double dabble) feeding a two-digit multiplexed
// seven-segment display with leading-zero blanking and a dash code for out-of-range values.
module seg7_dual_scan #(
    parameter int unsigned ticksPerDigit = 4,
    parameter bit          segActiveLow  = 1'b1
) (
    input  logic              clkIn,
    input  logic              rst,
    seg7_dual_scan_if.slave   bus
);

    localparam int unsigned VAL_W  = 7;
    localparam int unsigned BCD_W  = 8;
    localparam int unsigned ITER_W = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_W  = 4;

    localparam logic [DIG_W-1:0]  DIG_DASH  = 4'hA;
    localparam logic [DIG_W-1:0]  DIG_BLANK = 4'hB;
    localparam logic [ITER_W-1:0] LAST_ITER = 3'd6;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(ticksPerDigit - 1);
    localparam logic [VAL_W-1:0]  MAX_LEGAL = 7'd99;
    localparam logic [SEG_W-1:0]  SEG_ZERO  = 7'h3F;
    localparam logic [SEG_W-1:0]  SEG_RST   = segActiveLow ? ~SEG_ZERO : SEG_ZERO;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   bin_q,   bin_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [ITER_W-1:0]  iter_q,  iter_d;
    logic               ovf_q,   ovf_d;
    logic               busy_q,  busy_d;
    logic               err_q,   err_d;
    logic [DIG_W-1:0]   ones_q,  ones_d;
    logic [DIG_W-1:0]   tens_q,  tens_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               sel_q,   sel_d;
    logic [SEG_W-1:0]   seg_q,   seg_d;
    logic [1:0]         an_q,    an_d;

    logic [DIG_W-1:0]   lo_adj, hi_adj;
    logic [BCD_W-1:0]   bcd_adj;
    logic [DIG_W-1:0]   tens_shown;
    logic [SEG_W-1:0]   seg_active;

    function automatic logic [SEG_W-1:0] seg_code(input logic [DIG_W-1:0] d);
        logic [SEG_W-1:0] c;
        case (d)
            4'd0:     c = 7'h3F;
            4'd1:     c = 7'h06;
            4'd2:     c = 7'h5B;
            4'd3:     c = 7'h4F;
            4'd4:     c = 7'h66;
            4'd5:     c = 7'h6D;
            4'd6:     c = 7'h7D;
            4'd7:     c = 7'h07;
            4'd8:     c = 7'h7F;
            4'd9:     c = 7'h6F;
            DIG_DASH: c = 7'h40;
            default:  c = 7'h00;
        endcase
        return c;
    endfunction

    // Double-dabble correction applied before each shift
    always_comb begin
        lo_adj  = (bcd_q[3:0] >= 4'd5) ? DIG_W'(bcd_q[3:0] + 4'd3) : bcd_q[3:0];
        hi_adj  = (bcd_q[7:4] >= 4'd5) ? DIG_W'(bcd_q[7:4] + 4'd3) : bcd_q[7:4];
        bcd_adj = {hi_adj, lo_adj};
    end

    // Conversion controller next-state
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    bin_d   = bus.value;
                    bcd_d   = '0;
                    iter_d  = '0;
                    ovf_d   = (bus.value > MAX_LEGAL);
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[VAL_W-1]};
                bin_d  = {bin_q[VAL_W-2:0], 1'b0};
                iter_d = ITER_W'(iter_q + 3'd1);
                if (iter_q == LAST_ITER) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                err_d = ovf_q;
                if (ovf_q) begin
                    ones_d = DIG_DASH;
                    tens_d = DIG_DASH;
                end else begin
                    ones_d = bcd_q[3:0];
                    tens_d = bcd_q[7:4];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Free-running digit scan, independent of the converter
    always_comb begin
        cnt_d = CNT_W'(cnt_q + 8'd1);
        sel_d = sel_q;
        if (cnt_q >= CNT_MAX) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end
    end

    // Output patterns follow the next-cycle select/digits so seg and an stay aligned
    always_comb begin
        tens_shown = (!err_d && tens_d == 4'd0) ? DIG_BLANK : tens_d;
        seg_active = sel_d ? seg_code(tens_shown) : seg_code(ones_d);
        seg_d      = segActiveLow ? ~seg_active : seg_active;
        an_d       = sel_d ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ones_q  <= '0;
            tens_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            seg_q   <= SEG_RST;
            an_q    <= 2'b10;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.err  = err_q;
    assign bus.seg  = seg_q;
    assign bus.an   = an_q;

endmodule
